// File: rtl/merge_pkg.sv
// Shared definitions for the merge-tree sequencing controllers.
//   - Default tuple and key widths.
//   - FSM state encodings. Encoding 3 is unused and is treated as MERGE.
//   - The run terminator, which is the all-zero tuple.
//   - The per-cycle decision record produced by the select logic.
package merge_pkg;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int KEY_WIDTH_DEF  = 80;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_MERGE   = 2'd0;
  localparam logic [1:0] ST_DRAIN_A = 2'd1;
  localparam logic [1:0] ST_DRAIN_B = 2'd2;

  localparam logic [DATA_WIDTH_DEF-1:0] TERM_TUPLE = '0;

  // One cycle's worth of select/issue decision.
  typedef struct packed {
    logic   issue;    // a tuple goes out on the next edge
    logic   sel_b;    // issued tuple comes from B (else A)
    logic   deq_a;
    logic   deq_b;
    logic   last;     // issued tuple is the run terminator
    logic   run_inc;  // a complete output run finishes
    state_t nxt;
  } decision_t;

endpackage

// File: rtl/merge_select_ctrl_if.sv
// Handshake bundle between the two input FIFOs, the merge controller and the
// downstream FIFO.
//   i_a_data/i_a_empty, i_b_data/i_b_empty : FWFT heads of FIFO A and FIFO B
//   o_a_deq/o_b_deq                        : dequeue strobes (combinational)
//   i_credit_return                        : downstream popped one tuple
//   o_valid/o_data/o_last                  : registered output tuple
// The slave modport is the controller's view; the master modport is the view
// of the surrounding FIFOs and downstream logic.
interface merge_select_ctrl_if
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] i_a_data;
  logic                  i_a_empty;
  logic [DATA_WIDTH-1:0] i_b_data;
  logic                  i_b_empty;
  logic                  o_a_deq;
  logic                  o_b_deq;
  logic                  i_credit_return;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;

  modport slave (
    input  i_a_data, i_a_empty, i_b_data, i_b_empty, i_credit_return,
    output o_a_deq, o_b_deq, o_valid, o_data, o_last
  );

  modport master (
    output i_a_data, i_a_empty, i_b_data, i_b_empty, i_credit_return,
    input  o_a_deq, o_b_deq, o_valid, o_data, o_last
  );
endinterface

// File: rtl/merge_credit_counter.sv
// Saturating up/down credit counter shared by every merge-tree level.
//   i_clk, i_rst : clock, synchronous active-high reset (loads CREDITS)
//   i_take       : one credit consumed by an issue this cycle
//   i_return     : one credit given back by the downstream FIFO
//   o_avail      : registered credit is non-zero
// A return while already full is a protocol error; the counter saturates
// rather than wrapping so that one stray return cannot drain the gate.
module merge_credit_counter
  import merge_pkg::*;
#(
  parameter int CREDITS      = 16,
  parameter int CREDIT_WIDTH = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_take,
  input  logic i_return,
  output logic o_avail
);

  localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(CREDITS);

  logic [CREDIT_WIDTH-1:0] r_credit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_credit <= FULL;
    end else begin
      case ({i_take, i_return})
        2'b01: if (r_credit != FULL) r_credit <= r_credit + CREDIT_WIDTH'(1);
        2'b10: if (r_credit != '0)   r_credit <= r_credit - CREDIT_WIDTH'(1);
        default: ;  // idle, or take and return cancel out
      endcase
    end
  end

  assign o_avail = (r_credit != '0);

endmodule

// File: rtl/merge_select_ctrl.sv
// Sequencing controller for one 2-to-1 stage of the merge tree.
// Each cycle it picks the head of FIFO A or FIFO B (smaller key wins, ties go
// to A), dequeues it and registers it towards the bitonic merge datapath.
// All-zero tuples terminate a run: when one side reaches its terminator the
// other side is drained, then both terminators are consumed together and a
// single terminator is forwarded with o_last set.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : merge_select_ctrl_if.slave (FIFO heads, deq, credit, output)
//   o_state      : current FSM state (debug)
//   o_run_count  : completed output runs, wrapping
module merge_select_ctrl
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int KEY_WIDTH    = KEY_WIDTH_DEF,
  parameter int CREDITS      = 16,
  parameter int CREDIT_WIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  merge_select_ctrl_if.slave   bus,
  output logic [1:0]           o_state,
  output logic [15:0]          o_run_count
);

  localparam logic [DATA_WIDTH-1:0] TERM = DATA_WIDTH'(TERM_TUPLE);

  state_t                r_state;
  logic                  r_vld_p1;
  logic [DATA_WIDTH-1:0] r_data_p1;
  logic                  r_last_p1;
  logic [15:0]           r_run_count;

  logic      w_credit_ok;
  logic      w_a_term;
  logic      w_b_term;
  logic      w_a_le_b;
  state_t    w_cur;
  decision_t w_dec;

  merge_credit_counter #(
    .CREDITS      (CREDITS),
    .CREDIT_WIDTH (CREDIT_WIDTH)
  ) u_credit (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_take   (w_dec.issue),
    .i_return (bus.i_credit_return),
    .o_avail  (w_credit_ok)
  );

  assign w_a_term = ~bus.i_a_empty & (bus.i_a_data == TERM);
  assign w_b_term = ~bus.i_b_empty & (bus.i_b_data == TERM);
  assign w_a_le_b = (bus.i_a_data[KEY_WIDTH-1:0] <= bus.i_b_data[KEY_WIDTH-1:0]);
  assign w_cur    = (r_state == ST_DRAIN_A || r_state == ST_DRAIN_B) ? r_state : ST_MERGE;

  // Stage p0: select decision from the FIFO heads and registered credit.
  // The credit gate uses only registered credit, so i_credit_return never
  // reaches the dequeue strobes combinationally.
  always_comb begin
    w_dec     = '0;
    w_dec.nxt = w_cur;
    if (!i_rst && w_credit_ok) begin
      case (w_cur)
        ST_DRAIN_B: begin
          // A's terminator waits at its head until B's terminator arrives.
          if (!bus.i_b_empty) begin
            w_dec.issue = 1'b1;
            w_dec.sel_b = 1'b1;
            w_dec.deq_b = 1'b1;
            if (w_b_term) begin
              w_dec.deq_a   = ~bus.i_a_empty;
              w_dec.last    = 1'b1;
              w_dec.run_inc = 1'b1;
              w_dec.nxt     = ST_MERGE;
            end
          end
        end
        ST_DRAIN_A: begin
          if (!bus.i_a_empty) begin
            w_dec.issue = 1'b1;
            w_dec.deq_a = 1'b1;
            if (w_a_term) begin
              w_dec.deq_b   = ~bus.i_b_empty;
              w_dec.last    = 1'b1;
              w_dec.run_inc = 1'b1;
              w_dec.nxt     = ST_MERGE;
            end
          end
        end
        default: begin
          if (!bus.i_a_empty && !bus.i_b_empty) begin
            if (w_a_term && w_b_term) begin
              w_dec.issue   = 1'b1;
              w_dec.deq_a   = 1'b1;
              w_dec.deq_b   = 1'b1;
              w_dec.last    = 1'b1;
              w_dec.run_inc = 1'b1;
            end else if (w_a_term) begin
              w_dec.nxt = ST_DRAIN_B;
            end else if (w_b_term) begin
              w_dec.nxt = ST_DRAIN_A;
            end else begin
              // Ties favour A so equal keys keep their arrival order.
              w_dec.issue = 1'b1;
              w_dec.sel_b = ~w_a_le_b;
              w_dec.deq_a = w_a_le_b;
              w_dec.deq_b = ~w_a_le_b;
            end
          end
        end
      endcase
    end
  end

  // Stage p1: registered output tuple, FSM state and run counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_MERGE;
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
      r_last_p1   <= 1'b0;
      r_run_count <= '0;
    end else begin
      r_state  <= w_dec.nxt;
      r_vld_p1 <= w_dec.issue;
      r_last_p1 <= w_dec.issue & w_dec.last;
      if (w_dec.issue) r_data_p1 <= w_dec.sel_b ? bus.i_b_data : bus.i_a_data;
      if (w_dec.run_inc) r_run_count <= r_run_count + 16'd1;
    end
  end

  assign bus.o_a_deq = w_dec.deq_a;
  assign bus.o_b_deq = w_dec.deq_b;
  assign bus.o_valid = r_vld_p1;
  assign bus.o_data  = r_data_p1;
  assign bus.o_last  = r_last_p1;
  assign o_state     = r_state;
  assign o_run_count = r_run_count;

endmodule
